// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS HI/LO unit: iterative MULT/MULTU/DIV/DIVU plus MFHI/MFLO/MTHI/MTLO.
// Operates on magnitudes and applies the result sign in a final FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic                 dz_q, dz_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 op_mul;
    logic                 op_div;
    logic                 op_signed;
    logic                 s1;
    logic                 s2;
    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;
    logic                 last_iter;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_tmp;
    logic [WIDTH:0]       div_sub;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;

    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;

    assign op_mul    = (funct == F_MULT) || (funct == F_MULTU);
    assign op_div    = (funct == F_DIV) || (funct == F_DIVU);
    assign op_signed = (funct == F_MULT) || (funct == F_DIV);
    assign s1        = op_signed & in1[WIDTH-1];
    assign s2        = op_signed & in2[WIDTH-1];
    assign mag1      = s1 ? -in1 : in1;
    assign mag2      = s2 ? -in2 : in2;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // Shift-add: upper half accumulates, multiplier drains out of the low half.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + (prod_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    // Restoring divide: remainder in the upper half, quotient bits shift into the low half.
    assign div_tmp  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_sub  = div_tmp - {1'b0, opnd_q};
    assign div_ge   = (div_tmp >= {1'b0, opnd_q});
    assign div_next = {div_ge ? div_sub[WIDTH-1:0] : div_tmp[WIDTH-1:0],
                       prod_q[WIDTH-2:0], div_ge};

    assign prod_neg = -prod_q;
    assign quo      = prod_q[WIDTH-1:0];
    assign rem      = prod_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        opnd_d   = opnd_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (1'b1)
                        op_mul: begin
                            state_d  = S_MUL;
                            cnt_d    = '0;
                            prod_d   = {{WIDTH{1'b0}}, mag2};
                            opnd_d   = mag1;
                            neg_lo_d = s1 ^ s2;
                            neg_hi_d = s1 ^ s2;
                            dz_d     = 1'b0;
                            is_div_d = 1'b0;
                        end
                        op_div: begin
                            state_d  = S_DIV;
                            cnt_d    = '0;
                            prod_d   = {{WIDTH{1'b0}}, mag1};
                            opnd_d   = mag2;
                            neg_lo_d = s1 ^ s2;
                            neg_hi_d = s1;
                            dz_d     = (in2 == '0);
                            is_div_d = 1'b1;
                        end
                        (funct == F_MTHI): hi_d = in1;
                        (funct == F_MTLO): lo_d = in1;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q + CW'(1);
                if (last_iter) state_d = S_FIX;
            end
            S_DIV: begin
                prod_d = div_next;
                cnt_d  = cnt_q + CW'(1);
                if (last_iter) state_d = S_FIX;
            end
            S_FIX: begin
                // A zero divisor leaves the dividend as remainder; only the quotient is forced.
                if (is_div_q) begin
                    lo_d = dz_q ? '1 : (neg_lo_q ? -quo : quo);
                    hi_d = neg_hi_q ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? prod_neg : prod_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign out  = (funct == F_MFHI) ? hi_q :
                  (funct == F_MFLO) ? lo_q : '0;

endmodule
